sprite_ram_arbiter: RTL



---
 rtl/dd8_spr_pkg.sv | 13 +
 rtl/sprite_ram_arbiter_if.sv | 39 +++
 rtl/sprite_ram_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/dd8_spr_pkg.sv
// Shared sprite RAM definitions for the dd8 video subsystem.
package dd8_spr_pkg;

    localparam int unsigned SPR_ADDR_W = 15;
    localparam int unsigned SPR_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DMA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// Requester and RAM bus bundle for the sprite RAM arbiter.
interface sprite_ram_arbiter_if
    import dd8_spr_pkg::*;
#(
    parameter int unsigned ADDR_W = SPR_ADDR_W,
    parameter int unsigned DATA_W = SPR_DATA_W
) ();

    logic              blank;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic [DATA_W-1:0] d_data;
    logic              d_valid;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;
    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    // Environment side: requesters plus the RAM read port.
    modport master (
        output blank, d_req, d_addr, c_req, c_we, c_addr, c_wdata, m_rdata,
        input  d_gnt, d_data, d_valid, c_rdata, c_ack, m_addr, m_re, m_we, m_wdata
    );

    // Arbiter side.
    modport slave (
        input  blank, d_req, d_addr, c_req, c_we, c_addr, c_wdata, m_rdata,
        output d_gnt, d_data, d_valid, c_rdata, c_ack, m_addr, m_re, m_we, m_wdata
    );

endinterface

// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite RAM arbiter: DMA priority in active video, CPU priority in blank,
// starvation-bounded CPU wait, read data returned one cycle after the RAM access.
module sprite_ram_arbiter
    import dd8_spr_pkg::*;
#(
    parameter int unsigned ADDR_W       = SPR_ADDR_W,
    parameter int unsigned DATA_W       = SPR_DATA_W,
    parameter int unsigned CPU_MAX_WAIT = 4,
    parameter int unsigned WAIT_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sprite_ram_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

    owner_e            owner_q, owner_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_re_q, m_re_d;
    logic              m_we_q, m_we_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] d_data_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic              c_ack_q;

    logic c_inflight;
    logic c_elig;
    logic at_max;
    logic cpu_win;
    logic dma_win;

    always_comb begin
        // A CPU access is in flight exactly while the owner register tags it.
        c_inflight = (owner_q == OWN_CPU);
        c_elig     = bus.c_req && !c_inflight;
        at_max     = (wait_q == MAX_WAIT);
        cpu_win    = c_elig && (bus.blank || !bus.d_req || at_max);
        dma_win    = bus.d_req && !cpu_win && !rst;

        owner_d   = OWN_NONE;
        m_addr_d  = m_addr_q;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        m_wdata_d = m_wdata_q;
        wait_d    = wait_q;

        if (cpu_win) begin
            owner_d  = OWN_CPU;
            m_addr_d = bus.c_addr;
            m_re_d   = !bus.c_we;
            m_we_d   = bus.c_we;
            if (bus.c_we) begin
                m_wdata_d = bus.c_wdata;
            end
        end else if (dma_win) begin
            owner_d  = OWN_DMA;
            m_addr_d = bus.d_addr;
            m_re_d   = 1'b1;
        end

        if (!bus.c_req || cpu_win) begin
            wait_d = '0;
        end else if (c_elig && !at_max) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            wait_q    <= '0;
            m_addr_q  <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            d_data_q  <= '0;
            d_valid_q <= 1'b0;
            c_rdata_q <= '0;
            c_ack_q   <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            m_addr_q  <= m_addr_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            d_valid_q <= (owner_q == OWN_DMA);
            c_ack_q   <= (owner_q == OWN_CPU);
            if (owner_q == OWN_DMA) begin
                d_data_q <= bus.m_rdata;
            end
            // CPU writes complete with an ack but leave c_rdata untouched.
            if (owner_q == OWN_CPU && m_re_q) begin
                c_rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.d_gnt   = dma_win;
    assign bus.d_data  = d_data_q;
    assign bus.d_valid = d_valid_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_re    = m_re_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_wdata = m_wdata_q;

endmodule
